// File: rtl/frame_sequencer_pkg.sv
// Shared types and helpers for the frame sequencer: state encoding, field widths
// and the decoder-limit expansion.
package frame_sequencer_pkg;

  localparam int unsigned ANIM_W       = 6;
  localparam int unsigned FRAME_W      = 5;
  localparam int unsigned LIMIT_W      = 5;
  localparam int unsigned EFF_W        = 6;
  localparam int unsigned SPEED_W      = 3;
  localparam int unsigned NUM_ANIM_DEF = 51;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // A decoder limit of 0 stands for a full 32-frame animation.
  function automatic logic [EFF_W-1:0] eff_limit(input logic [LIMIT_W-1:0] lim);
    return (lim == '0) ? EFF_W'(32) : {1'b0, lim};
  endfunction

endpackage

// File: rtl/frame_prescaler.sv
// Programmable-rate prescaler: counts while run is high and flags the terminal
// count of a period of BASE_DIV >> speed cycles (a zero period ticks every cycle).
module frame_prescaler
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned BASE_DIV = 1000000,
  parameter int unsigned DIV_W    = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               clear,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick_c
);

  localparam int unsigned PER_W = DIV_W + 1;

  logic [DIV_W-1:0] count;
  logic [PER_W-1:0] period_c;
  logic [PER_W-1:0] term_c;

  // >= rather than == so a speed change that lands below the count ticks at once.
  always_comb begin
    period_c = PER_W'(BASE_DIV) >> speed;
    term_c   = (period_c == '0) ? '0 : period_c - PER_W'(1);
    tick_c   = run && ({1'b0, count} >= term_c);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick_c ? '0 : count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: selects the animation (manual pins or auto-cycling) and steps
// the frame index at a programmable rate against the decoder-supplied limit.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ANIM = NUM_ANIM_DEF,
  parameter int unsigned BASE_DIV = 1000000,
  parameter int unsigned DIV_W    = 20,
  parameter int unsigned LOOPS    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               auto_mode,
  input  logic [ANIM_W-1:0]  sel_anim,
  input  logic               btn_next,
  input  logic [SPEED_W-1:0] speed,
  input  logic [LIMIT_W-1:0] limit,
  output logic [ANIM_W-1:0]  animation,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_strobe,
  output logic               wrap
);

  localparam int unsigned LOOP_W = (LOOPS < 2) ? 1 : $clog2(LOOPS + 1);
  localparam logic [ANIM_W-1:0] LAST_ANIM = ANIM_W'(NUM_ANIM - 1);

  state_t              state;
  state_t              state_d;
  logic [ANIM_W-1:0]   anim_d;
  logic [ANIM_W-1:0]   target_c;
  logic [FRAME_W-1:0]  frame_d;
  logic                strobe_d;
  logic                wrap_d;
  logic [LOOP_W-1:0]   loop_cnt;
  logic [LOOP_W-1:0]   loop_d;
  logic [LOOP_W-1:0]   loop_inc_c;
  logic [2:0]          btn_sync;
  logic                btn_edge_c;
  logic                load_req_c;
  logic                run_c;
  logic                clear_c;
  logic                tick_c;
  logic [EFF_W-1:0]    eff_c;
  logic [EFF_W-1:0]    frame_inc_c;

  assign run_c = (state == S_RUN) && ena;

  frame_prescaler #(
    .BASE_DIV (BASE_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .run    (run_c),
    .clear  (clear_c),
    .speed  (speed),
    .tick_c (tick_c)
  );

  // Two sync flops then a delayed copy for rising-edge detection.
  assign btn_edge_c = btn_sync[1] & ~btn_sync[2];

  always_comb begin
    if (auto_mode) begin
      target_c   = (animation == LAST_ANIM) ? '0 : animation + ANIM_W'(1);
      load_req_c = btn_edge_c;
    end else begin
      target_c   = (sel_anim > LAST_ANIM) ? LAST_ANIM : sel_anim;
      load_req_c = (target_c != animation);
    end
  end

  assign eff_c       = eff_limit(limit);
  assign frame_inc_c = EFF_W'(frame) + EFF_W'(1);
  assign loop_inc_c  = loop_cnt + LOOP_W'(1);

  // Next-state and output decode; a load request outranks hold and tick.
  always_comb begin
    state_d  = state;
    anim_d   = animation;
    frame_d  = frame;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;
    loop_d   = auto_mode ? loop_cnt : '0;
    clear_c  = 1'b0;
    case (state)
      S_LOAD: begin
        anim_d   = target_c;
        frame_d  = '0;
        loop_d   = '0;
        clear_c  = 1'b1;
        strobe_d = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (load_req_c) begin
          state_d = S_LOAD;
        end else if (!ena) begin
          state_d = S_HOLD;
        end else if (tick_c) begin
          strobe_d = 1'b1;
          if (frame_inc_c >= eff_c) begin
            frame_d = '0;
            wrap_d  = 1'b1;
            if (auto_mode) begin
              loop_d = loop_inc_c;
              if (loop_inc_c >= LOOP_W'(LOOPS)) begin
                state_d = S_LOAD;
              end
            end
          end else begin
            frame_d = frame + FRAME_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (load_req_c) begin
          state_d = S_LOAD;
        end else if (ena) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LOAD;
      animation    <= '0;
      frame        <= '0;
      frame_strobe <= 1'b0;
      wrap         <= 1'b0;
      loop_cnt     <= '0;
      btn_sync     <= '0;
    end else begin
      state        <= state_d;
      animation    <= anim_d;
      frame        <= frame_d;
      frame_strobe <= strobe_d;
      wrap         <= wrap_d;
      loop_cnt     <= loop_d;
      btn_sync     <= {btn_sync[1:0], btn_next};
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed scenarios plus a random phase, every cycle
// compared against a behavioural model of the sequencing rules.
module tb_frame_sequencer;

  localparam int BD = 8;
  localparam int LP = 2;
  localparam int NA = 51;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       auto_mode;
  logic [5:0] sel_anim;
  logic       btn_next;
  logic [2:0] speed;
  logic [4:0] limit;
  logic [5:0] animation;
  logic [4:0] frame;
  logic       frame_strobe;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  int m_anim, m_frame, m_strobe, m_wrap, m_cnt, m_loops;
  bit m_load, m_hold;
  bit b1, b2, b3;
  bit dec_en;

  frame_sequencer #(
    .NUM_ANIM (NA),
    .BASE_DIV (BD),
    .DIV_W    (4),
    .LOOPS    (LP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ena          (ena),
    .auto_mode    (auto_mode),
    .sel_anim     (sel_anim),
    .btn_next     (btn_next),
    .speed        (speed),
    .limit        (limit),
    .animation    (animation),
    .frame        (frame),
    .frame_strobe (frame_strobe),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  // Stand-in for the animation-to-limit decoder; animation 27 yields 0 (32 frames).
  function automatic int dec_limit(input int a);
    return (a * 7 + 3) % 32;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the inputs present at that edge.
  task automatic model_step();
    int  eff, per, tgt;
    bit  edge_now, tick, want_load;
    if (reset) begin
      m_anim = 0; m_frame = 0; m_strobe = 0; m_wrap = 0; m_cnt = 0; m_loops = 0;
      m_load = 1; m_hold = 0; b1 = 0; b2 = 0; b3 = 0;
      return;
    end
    edge_now = b2 && !b3;
    b3 = b2; b2 = b1; b1 = btn_next;
    eff = (limit == 0) ? 32 : int'(limit);
    per = BD >> speed;
    if (per == 0) per = 1;
    if (auto_mode) tgt = (m_anim == NA - 1) ? 0 : m_anim + 1;
    else           tgt = (int'(sel_anim) > NA - 1) ? NA - 1 : int'(sel_anim);
    want_load = auto_mode ? edge_now : (tgt != m_anim);
    m_strobe = 0;
    m_wrap   = 0;
    if (!auto_mode) m_loops = 0;
    if (m_load) begin
      m_anim = tgt; m_frame = 0; m_cnt = 0; m_loops = 0;
      m_strobe = 1; m_load = 0; m_hold = 0;
    end else if (want_load) begin
      m_load = 1;
    end else if (m_hold) begin
      if (ena) m_hold = 0;
    end else if (!ena) begin
      m_hold = 1;
    end else begin
      tick  = (m_cnt >= per - 1);
      m_cnt = tick ? 0 : m_cnt + 1;
      if (tick) begin
        m_strobe = 1;
        if (m_frame + 1 >= eff) begin
          m_frame = 0;
          m_wrap  = 1;
          if (auto_mode) begin
            m_loops++;
            if (m_loops >= LP) m_load = 1;
          end
        end else begin
          m_frame++;
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check("animation", animation, m_anim);
      check("frame", frame, m_frame);
      check("frame_strobe", frame_strobe, m_strobe);
      check("wrap", wrap, m_wrap);
      if (dec_en) limit = 5'(dec_limit(m_anim));
    end
  endtask

  initial begin
    int a0;
    int unsigned r;
    reset = 1'b1; ena = 1'b1; auto_mode = 1'b0; sel_anim = '0; btn_next = 1'b0;
    speed = 3'd0; limit = 5'd10; dec_en = 1'b0;
    m_anim = 0; m_frame = 0; m_strobe = 0; m_wrap = 0; m_cnt = 0; m_loops = 0;
    m_load = 1; m_hold = 0; b1 = 0; b2 = 0; b3 = 0;

    cyc(3);
    check("rst_animation", animation, 0);
    check("rst_frame", frame, 0);
    check("rst_strobe", frame_strobe, 0);
    check("rst_wrap", wrap, 0);

    // Manual animation 0, ten frames, one step per 8 cycles.
    reset = 1'b0;
    cyc(1);
    check("load_strobe", frame_strobe, 1);
    cyc(100);

    // 32-frame animation at a period of one cycle.
    limit = 5'd0; speed = 3'd3;
    cyc(80);

    // Auto from animation 50: two passes then rollover to 0.
    sel_anim = 6'd50; limit = 5'd5;
    cyc(3);
    check("sel_50", animation, 50);
    auto_mode = 1'b1;
    cyc(12);
    check("auto_rollover", animation, 0);

    // Button edge landing on a tick at frame 3.
    speed = 3'd0; limit = 5'd10;
    cyc(4);
    for (int i = 0; i < 300 && !(m_frame == 3 && m_cnt == 5 && !m_load && !m_hold); i++) cyc(1);
    check("btn_align_wait", (m_frame == 3 && m_cnt == 5), 1);
    a0 = m_anim;
    btn_next = 1'b1;
    cyc(3);
    btn_next = 1'b0;
    check("btn_no_wrap", wrap, 0);
    cyc(1);
    check("btn_adv1", animation, (a0 + 1) % NA);
    check("btn_frame0", frame, 0);
    cyc(10);
    btn_next = 1'b1;
    cyc(3);
    btn_next = 1'b0;
    cyc(2);
    check("btn_adv2", animation, (a0 + 2) % NA);

    // Manual clamp, then a selection change while disabled.
    auto_mode = 1'b0; sel_anim = 6'd60;
    cyc(4);
    check("clamp_50", animation, 50);
    ena = 1'b0;
    cyc(3);
    sel_anim = 6'd7;
    cyc(6);
    check("hold_anim7", animation, 7);
    check("hold_frame0", frame, 0);
    cyc(20);
    check("hold_still0", frame, 0);
    ena = 1'b1;
    cyc(30);

    // Reset in the middle of animation 1.
    sel_anim = 6'd1; limit = 5'd10; speed = 3'd0;
    cyc(4);
    for (int i = 0; i < 300 && !(m_anim == 1 && m_frame == 7); i++) cyc(1);
    check("frame7_wait", (m_anim == 1 && m_frame == 7), 1);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_animation", animation, 0);
    check("mid_rst_frame", frame, 0);
    check("mid_rst_strobe", frame_strobe, 0);
    check("mid_rst_wrap", wrap, 0);
    reset = 1'b0;
    cyc(1);
    check("post_rst_load", frame_strobe, 1);
    check("post_rst_anim", animation, 1);

    // Random phase with the decoder stand-in driving limit.
    dec_en = 1'b1;
    limit  = 5'(dec_limit(m_anim));
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 30) speed = 3'($urandom_range(0, 7));
      ena = ($urandom_range(0, 99) < 92);
      if ($urandom_range(0, 99) < 2) auto_mode = ~auto_mode;
      if ($urandom_range(0, 99) < 3) sel_anim = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 99) < 10) btn_next = ~btn_next;
      reset = ($urandom_range(0, 999) < 3);
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
